// File: rtl/crt_reset_pkg.sv
// Shared types and default parameters for the video pipeline reset sequencer.
// The counter width helper keeps the shared hold/gap counter sized in one place.
package crt_reset_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } crt_state_e;

   localparam int unsigned DEF_NUM_STAGES  = 3;
   localparam int unsigned DEF_HOLD_CYCLES = 16;
   localparam int unsigned DEF_GAP_CYCLES  = 4;

   function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
      return $clog2(((hold > gap) ? hold : gap) + 1);
   endfunction

endpackage

// File: rtl/crt_reset_sequencer.sv
// Ordered per-stage reset release for the pixel-domain video pipeline, gated on
// a minimum PLL lock time, with a four-phase soft-reset handshake that re-runs it.
module crt_reset_sequencer
   import crt_reset_pkg::*;
#(
   parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
   input  logic                  clk,
   input  logic                  async_rst_n,
   input  logic                  pll_locked,
   input  logic                  soft_rst_req,
   output logic                  soft_rst_ack,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  all_released,
   output logic                  busy
);

   localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int unsigned CNT_TOP = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CNT_TOP);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

   crt_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic                  pending_q, pending_d;
   logic                  ack_q, ack_d;
   logic                  all_rel_q, all_rel_d;
   logic                  busy_q, busy_d;
   logic                  req_new;

   // The counter is shared between hold and gap phases and must never wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      stage_d   = stage_q;
      ack_d     = ack_q;
      req_new   = soft_rst_req && !ack_q;
      pending_d = pending_q || req_new;

      if (ack_q && !soft_rst_req) begin
         ack_d = 1'b0;
      end

      if (!pll_locked) begin
         state_d = ST_ASSERT;
         cnt_d   = '0;
         idx_d   = '0;
         stage_d = '0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d      = '0;
                  stage_d[0] = 1'b1;
                  if (NUM_STAGES == 1) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_RELEASE;
                     idx_d   = IDX_W'(1);
                  end
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            ST_RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d          = '0;
                  stage_d[idx_q] = 1'b1;
                  if (idx_q == IDX_LAST) begin
                     state_d = ST_RUN;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            ST_RUN: begin
               if (req_new) begin
                  state_d = ST_ASSERT;
                  cnt_d   = '0;
                  idx_d   = '0;
                  stage_d = '0;
               end
            end
            default: begin
               state_d = ST_ASSERT;
               cnt_d   = '0;
               idx_d   = '0;
               stage_d = '0;
            end
         endcase
      end

      // A completed sequence satisfies any request seen while it was running.
      if (state_d == ST_RUN && state_q != ST_RUN && pending_d) begin
         ack_d     = 1'b1;
         pending_d = 1'b0;
      end

      all_rel_d = (state_d == ST_RUN);
      busy_d    = (state_d != ST_RUN);
   end

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state_q   <= ST_ASSERT;
         cnt_q     <= '0;
         idx_q     <= '0;
         stage_q   <= '0;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
         all_rel_q <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         stage_q   <= stage_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         all_rel_q <= all_rel_d;
         busy_q    <= busy_d;
      end
   end

   assign stage_rst_n  = stage_q;
   assign soft_rst_ack = ack_q;
   assign all_released = all_rel_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_crt_reset_sequencer.sv
// Scoreboard bench for crt_reset_sequencer: a release-time model predicts every
// edge's outputs, directed scenarios pin the documented edge numbers.
module tb_crt_reset_sequencer;

   localparam int NUM  = 3;
   localparam int HOLD = 16;
   localparam int GAP  = 4;
   localparam int TCAP = 1000000;

   logic           clk;
   logic           async_rst_n;
   logic           pll_locked;
   logic           soft_rst_req;
   logic           soft_rst_ack;
   logic [NUM-1:0] stage_rst_n;
   logic           all_released;
   logic           busy;

   crt_reset_sequencer #(
      .NUM_STAGES (NUM),
      .HOLD_CYCLES(HOLD),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .pll_locked  (pll_locked),
      .soft_rst_req(soft_rst_req),
      .soft_rst_ack(soft_rst_ack),
      .stage_rst_n (stage_rst_n),
      .all_released(all_released),
      .busy        (busy)
   );

   typedef struct {
      logic [NUM-1:0] st;
      logic           ar;
      logic           bz;
      logic           ak;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model: m_t counts locked edges since the sequence (re)started.
   int   m_t    = 0;
   bit   m_pend = 0;
   bit   m_ack  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rel_count(input int t);
      int r;
      if (t < HOLD) return 0;
      r = (t - HOLD) / GAP + 1;
      return (r > NUM) ? NUM : r;
   endfunction

   task automatic model_step(input bit lk, input bit rq);
      int  before_n;
      bit  new_req;
      before_n = rel_count(m_t);
      new_req  = rq && !m_ack;
      if (!lk) m_t = 0;
      else if (before_n == NUM && new_req) m_t = 0;
      else if (m_t < TCAP) m_t++;
      m_pend = m_pend || new_req;
      if (m_ack && !rq) m_ack = 0;
      if (rel_count(m_t) == NUM && before_n != NUM && m_pend) begin
         m_ack  = 1;
         m_pend = 0;
      end
   endtask

   // Called at a negedge: drive inputs, predict the next edge, wait one cycle.
   task automatic cycle(input bit lk, input bit rq);
      exp_t e;
      int   n;
      pll_locked   = lk;
      soft_rst_req = rq;
      model_step(lk, rq);
      n    = rel_count(m_t);
      e.st = NUM'((1 << n) - 1);
      e.ar = (n == NUM);
      e.bz = (n != NUM);
      e.ak = m_ack;
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_stage"}, 32'(stage_rst_n), 32'(0));
      chk({tag, "_all"},   32'(all_released), 32'(0));
      chk({tag, "_ack"},   32'(soft_rst_ack), 32'(0));
      chk({tag, "_busy"},  32'(busy), 32'(1));
   endtask

   task automatic do_reset();
      async_rst_n  = 1'b0;
      pll_locked   = 1'b0;
      soft_rst_req = 1'b0;
      #1;
      chk_reset_vals("rst");
      @(negedge clk);
      m_t = 0; m_pend = 0; m_ack = 0;
      async_rst_n = 1'b1;
   endtask

   // Mid-cycle pulse, checked before any clock edge can occur.
   task automatic async_pulse();
      #2;
      async_rst_n = 1'b0;
      #1;
      chk_reset_vals("arst");
      soft_rst_req = 1'b0;
      @(negedge clk);
      m_t = 0; m_pend = 0; m_ack = 0;
      async_rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("sb_stage", 32'(stage_rst_n),  32'(e.st));
         chk("sb_all",   32'(all_released), 32'(e.ar));
         chk("sb_busy",  32'(busy),         32'(e.bz));
         chk("sb_ack",   32'(soft_rst_ack), 32'(e.ak));
      end
   end

   initial begin
      int  rises;
      bit  prev_ack;
      bit  req_r;
      bit  lk;
      bit  quiet;
      logic [NUM-1:0] exp_s;

      async_rst_n  = 1'b1;
      pll_locked   = 1'b0;
      soft_rst_req = 1'b0;
      #1;
      @(negedge clk);

      // Plain power-up release, then a soft request from RUN at edge 100.
      do_reset();
      for (int e = 1; e <= 99; e++) begin
         cycle(1, 0);
         if (e <= 30) begin
            exp_s = (e >= 24) ? 3'b111 : (e >= 20) ? 3'b011 : (e >= 16) ? 3'b001 : 3'b000;
            chk("t1_stage", 32'(stage_rst_n), 32'(exp_s));
            chk("t1_busy",  32'(busy), 32'(e < 24));
            chk("t1_all",   32'(all_released), 32'(e >= 24));
         end
      end
      for (int e = 100; e <= 131; e++) begin
         cycle(1, e <= 130);
         if (e == 100) chk("t4_low",   32'(stage_rst_n), 32'(0));
         if (e == 115) chk("t4_115",   32'(stage_rst_n), 32'(0));
         if (e == 116) chk("t4_116",   32'(stage_rst_n), 32'(3'b001));
         if (e == 120) chk("t4_120",   32'(stage_rst_n), 32'(3'b011));
         if (e == 123) chk("t4_noack", 32'(soft_rst_ack), 32'(0));
         if (e == 124) chk("t4_124",   32'({stage_rst_n, soft_rst_ack}), 32'(4'b1111));
         if (e == 130) chk("t4_ackhi", 32'(soft_rst_ack), 32'(1));
         if (e == 131) chk("t4_acklo", 32'(soft_rst_ack), 32'(0));
      end

      // One-cycle lock drop during the hold phase.
      do_reset();
      for (int e = 1; e <= 30; e++) begin
         cycle(e != 10, 0);
         if (e == 25) chk("t2_25", 32'(stage_rst_n), 32'(0));
         if (e == 26) chk("t2_26", 32'(stage_rst_n), 32'(3'b001));
      end

      // Lock drop during the release phase.
      do_reset();
      for (int e = 1; e <= 46; e++) begin
         cycle(e != 22, 0);
         if (e == 21) chk("t3_21", 32'(stage_rst_n), 32'(3'b011));
         if (e == 22) chk("t3_22", 32'({stage_rst_n, busy}), 32'(4'b0001));
         if (e == 37) chk("t3_37", 32'(stage_rst_n), 32'(0));
         if (e == 38) chk("t3_38", 32'(stage_rst_n), 32'(3'b001));
         if (e == 46) chk("t3_46", 32'(stage_rst_n), 32'(3'b111));
      end

      // Soft request and lock drop on the same edge: one sequence, one ack.
      cycle(0, 1);
      chk("t5_low", 32'(stage_rst_n), 32'(0));
      rises = 0;
      prev_ack = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         cycle(1, 1);
         if (soft_rst_ack && !prev_ack) rises++;
         if (i == 24) chk("t5_ack24", 32'({all_released, soft_rst_ack}), 32'(2'b11));
         prev_ack = soft_rst_ack;
      end
      cycle(1, 0);
      chk("t5_rises", 32'(rises), 32'(1));
      chk("t5_acklo", 32'(soft_rst_ack), 32'(0));

      // Async pulse mid-release with a pending request: no ack afterwards.
      do_reset();
      for (int e = 1; e <= 21; e++) cycle(1, e >= 18);
      async_pulse();
      rises = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(1, 0);
         if (soft_rst_ack) rises++;
      end
      chk("t6_noack", 32'(rises), 32'(0));
      chk("t6_all",   32'(all_released), 32'(1));

      // Randomized traffic: lock glitches, handshakes, protocol abuse, async pulses.
      req_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         quiet = ((i / 200) % 2) == 1;
         lk = quiet ? 1'b1 : ($urandom_range(0, 29) != 0);
         if (!req_r && !m_ack && $urandom_range(0, 19) == 0) req_r = 1'b1;
         else if (req_r && m_ack && $urandom_range(0, 3) == 0) req_r = 1'b0;
         else if ($urandom_range(0, 49) == 0) req_r = ~req_r;
         if ($urandom_range(0, 499) == 0) begin
            async_pulse();
            req_r = 1'b0;
         end
         cycle(lk, req_r);
      end

      chk("sb_drain", 32'(sb_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
